mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single data-memory port between instruction fetch (F, read-only) and load/store (D).
//   Round-robin arbitration; sequences sync-read latency and MMIO write completion handshake.
//   Sits between the pipeline stages and the memory module; lets one memory serve both streams.
// PARAMETERS
//   XLEN          32           data/address width
//   MMIO_START    32'h0000_0000 first MMIO address (inclusive)
//   MMIO_END      32'h0000_FFFF last MMIO address (inclusive)
//   MMIO_TIMEOUT  1024         max MMIO_WAIT cycles before abort; 0 = never abort
// PORTS
//   clock               in  1             clock
//   reset               in  1             reset, synchronous, active-high
//   d_req               in  1             D access request; hold until d_gnt
//   d_addr              in  XLEN          D byte address
//   d_w_enable          in  1             1 = write, 0 = read
//   d_w_data            in  XLEN          D write data
//   d_w_width           in  write_width_t D write width
//   d_gnt               out 1             D request accepted this cycle
//   d_done              out 1             1-cycle pulse: D read data valid / write finished
//   d_err               out 1             with d_done: MMIO write timed out
//   d_r_data            out XLEN          D read data, valid while d_done
//   f_req               in  1             F read request; hold until f_gnt
//   f_addr              in  XLEN          F byte address
//   f_gnt               out 1             F request accepted this cycle
//   f_done              out 1             1-cycle pulse: F read data valid
//   f_r_data            out XLEN          F read data, valid while f_done
//   mem_addr            out XLEN          memory address
//   mem_w_enable        out 1             memory write strobe
//   mem_w_data          out XLEN          memory write data
//   mem_w_width         out write_width_t memory write width
//   mem_r_data          in  XLEN          memory read data, 1 cycle after address
//   mmio_write_complete in  1             MMIO device accepted current write
// BEHAVIOUR
//   States: IDLE, READ_WAIT, MMIO_WAIT. Reset -> IDLE, last_winner=F, timeout counter=0;
//     all gnt/done/err/mem_w_enable = 0; r_data outputs 0; reset mid-access abandons it, no done.
//   IDLE, arbitration (comb, same cycle): one requester -> it wins; both -> the one != last_winner.
//     Winner's addr/w_* drive mem_* combinationally; winner's gnt=1; last_winner <= winner.
//     Addr/data/width/we/owner latched on grant; requester may change inputs after gnt.
//   Read grant: mem_w_enable=0 -> READ_WAIT. Next cycle mem_addr holds latched addr,
//     owner done=1, r_data=mem_r_data -> IDLE. Latency gnt->done = 1 cycle; 2 cycles/access.
//   RAM write grant (addr outside MMIO range): mem_w_enable=1 in grant cycle; d_done=1
//     registered next cycle; state stays IDLE (next grant possible in that same cycle).
//   MMIO write grant (MMIO_START<=addr<=MMIO_END): mem_w_enable=1 in grant cycle ->
//     MMIO_WAIT; mem_* driven from latched values, mem_w_enable=1 until exit.
//     Completion: mmio_write_complete=1 (incl. grant cycle: then skip MMIO_WAIT) -> d_done=1 next cycle, IDLE.
//     Timeout: counter increments each MMIO_WAIT cycle; reaching MMIO_TIMEOUT with no complete
//       -> d_done=1,d_err=1 next cycle, mem_w_enable drops, IDLE. Complete same cycle as limit: complete wins, no err.
//   No grants in READ_WAIT or MMIO_WAIT; pending reqs served on return to IDLE.
//   Outside accesses mem_w_enable=0, mem_addr/w_data don't care (drive 0). gnt never both 1.
//   Address comparisons unsigned, full XLEN; no alignment checks here.
// TESTING
//   F-only read addr 0x10 (mem holds 0xDEADBEEF) -> f_gnt cyc0, f_done cyc1, f_r_data=0xDEADBEEF.
//   d_req,f_req both held after reset -> grants D,F,D,F alternating, each 2 cycles apart, never both.
//   D RAM write 0x20000 data 0x12345678 -> mem_w_enable 1 cycle, d_done next cycle, readback matches.
//   D MMIO write, complete after 5 cycles -> mem_w_enable high 6 cycles, d_done=1 d_err=0; F stalls throughout.
//   MMIO_TIMEOUT=8, complete never -> d_done=d_err=1 after 8 wait cycles, mem_w_enable drops, F then granted.
//   reset asserted in READ_WAIT and in MMIO_WAIT -> no done pulse, outputs 0, IDLE, next grant to D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one synchronous-read memory port between instruction fetch
// and load/store, including read latency and MMIO write completion/timeout.
package mem_port_arbiter_pkg;
    typedef logic [1:0] write_width_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] MMIO_START   = 32'h0000_0000,
    parameter logic [XLEN-1:0] MMIO_END     = 32'h0000_FFFF,
    parameter int unsigned     MMIO_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               d_req,
    input  logic [XLEN-1:0]    d_addr,
    input  logic               d_w_enable,
    input  logic [XLEN-1:0]    d_w_data,
    input  write_width_t       d_w_width,
    output logic               d_gnt,
    output logic               d_done,
    output logic               d_err,
    output logic [XLEN-1:0]    d_r_data,
    input  logic               f_req,
    input  logic [XLEN-1:0]    f_addr,
    output logic               f_gnt,
    output logic               f_done,
    output logic [XLEN-1:0]    f_r_data,
    output logic [XLEN-1:0]    mem_addr,
    output logic               mem_w_enable,
    output logic [XLEN-1:0]    mem_w_data,
    output write_width_t       mem_w_width,
    input  logic [XLEN-1:0]    mem_r_data,
    input  logic               mmio_write_complete
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, MMIO_WAIT} state_t;
    typedef enum logic {OWNER_F, OWNER_D} owner_t;

    localparam logic [31:0] WAIT_LIMIT = MMIO_TIMEOUT - 1;

    state_t          state, state_next;
    owner_t          last_winner, last_winner_next;
    owner_t          owner, owner_next;
    logic [XLEN-1:0] lat_addr, addr_next;
    logic [XLEN-1:0] lat_data, data_next;
    write_width_t    lat_width, width_next;
    logic [31:0]     wait_cnt, wait_cnt_next;
    logic            done_q, done_next;
    logic            err_q, err_next;

    // Offset form keeps the range check valid even when MMIO_START is zero.
    function automatic logic in_mmio(input logic [XLEN-1:0] a);
        return (a - MMIO_START) <= (MMIO_END - MMIO_START);
    endfunction

    always_comb begin
        state_next       = state;
        last_winner_next = last_winner;
        owner_next       = owner;
        addr_next        = lat_addr;
        data_next        = lat_data;
        width_next       = lat_width;
        wait_cnt_next    = '0;
        done_next        = 1'b0;
        err_next         = 1'b0;
        d_gnt            = 1'b0;
        f_gnt            = 1'b0;
        d_done           = done_q;
        d_err            = err_q;
        f_done           = 1'b0;
        d_r_data         = '0;
        f_r_data         = '0;
        mem_addr         = '0;
        mem_w_enable     = 1'b0;
        mem_w_data       = '0;
        mem_w_width      = '0;

        // Synchronous reset still masks every output in the reset cycle itself.
        if (reset) begin
            d_done = 1'b0;
            d_err  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && (!f_req || last_winner == OWNER_F)) begin
                        d_gnt            = 1'b1;
                        mem_addr         = d_addr;
                        mem_w_enable     = d_w_enable;
                        mem_w_data       = d_w_data;
                        mem_w_width      = d_w_width;
                        last_winner_next = OWNER_D;
                        owner_next       = OWNER_D;
                        addr_next        = d_addr;
                        data_next        = d_w_data;
                        width_next       = d_w_width;
                        if (!d_w_enable) begin
                            state_next = READ_WAIT;
                        end else if (in_mmio(d_addr) && !mmio_write_complete) begin
                            state_next = MMIO_WAIT;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else if (f_req) begin
                        f_gnt            = 1'b1;
                        mem_addr         = f_addr;
                        last_winner_next = OWNER_F;
                        owner_next       = OWNER_F;
                        addr_next        = f_addr;
                        data_next        = '0;
                        width_next       = '0;
                        state_next       = READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    mem_addr    = lat_addr;
                    mem_w_data  = lat_data;
                    mem_w_width = lat_width;
                    if (owner == OWNER_D) begin
                        d_done   = 1'b1;
                        d_r_data = mem_r_data;
                    end else begin
                        f_done   = 1'b1;
                        f_r_data = mem_r_data;
                    end
                    state_next = IDLE;
                end
                MMIO_WAIT: begin
                    mem_addr     = lat_addr;
                    mem_w_enable = 1'b1;
                    mem_w_data   = lat_data;
                    mem_w_width  = lat_width;
                    if (mmio_write_complete) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (MMIO_TIMEOUT != 0 && wait_cnt == WAIT_LIMIT) begin
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (MMIO_TIMEOUT != 0) begin
                        wait_cnt_next = wait_cnt + 32'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= OWNER_F;
            owner       <= OWNER_F;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_width   <= '0;
            wait_cnt    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
            owner       <= owner_next;
            lat_addr    <= addr_next;
            lat_data    <= data_next;
            lat_width   <= width_next;
            wait_cnt    <= wait_cnt_next;
            done_q      <= done_next;
            err_q       <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// MMIO completion/timeout and mid-access reset sequences, against a small memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TIMEOUT = 8;

    logic         clock;
    logic         reset;
    logic         d_req, d_w_enable, d_gnt, d_done, d_err;
    logic [31:0]  d_addr, d_w_data, d_r_data;
    write_width_t d_w_width, mem_w_width;
    logic         f_req, f_gnt, f_done;
    logic [31:0]  f_addr, f_r_data;
    logic [31:0]  mem_addr, mem_w_data, mem_r_data;
    logic         mem_w_enable, mmio_write_complete;
    logic [5:0]   act_flags;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .XLEN(32),
        .MMIO_START(32'h0000_0000),
        .MMIO_END(32'h0000_FFFF),
        .MMIO_TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_w_enable(d_w_enable),
        .d_w_data(d_w_data), .d_w_width(d_w_width),
        .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_r_data(d_r_data),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_r_data(f_r_data),
        .mem_addr(mem_addr), .mem_w_enable(mem_w_enable), .mem_w_data(mem_w_data),
        .mem_w_width(mem_w_width), .mem_r_data(mem_r_data),
        .mmio_write_complete(mmio_write_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign act_flags = {d_gnt, f_gnt, d_done, f_done, d_err, mem_w_enable};

    // Memory: fixed preload contents with a write overlay, synchronous read.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEAD_BEEF;
            32'h40:  return 32'hCAFE_F00D;
            32'h44:  return 32'h0BAD_C0DE;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] wr_mem   [0:255];
    logic [31:0] wr_tag   [0:255];
    logic        wr_valid [0:255];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
        end else if (mem_w_enable) begin
            wr_valid[mem_addr[9:2]] <= 1'b1;
            wr_tag[mem_addr[9:2]]   <= mem_addr;
            wr_mem[mem_addr[9:2]]   <= mem_w_data;
        end
        mem_r_data <= (wr_valid[mem_addr[9:2]] && wr_tag[mem_addr[9:2]] == mem_addr)
                      ? wr_mem[mem_addr[9:2]] : rom(mem_addr);
    end

    typedef struct {
        logic        dr;
        logic [31:0] da;
        logic        dw;
        logic [31:0] dd;
        logic        fr;
        logic [31:0] fa;
        logic        mc;
        logic [5:0]  flags;   // {d_gnt,f_gnt,d_done,f_done,d_err,mem_w_enable}
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [31:0] frd;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic dr, input logic [31:0] da, input logic dw,
                                input logic [31:0] dd, input logic fr, input logic [31:0] fa,
                                input logic mc, input logic [5:0] flags, input logic [31:0] ma,
                                input logic [31:0] mwd, input logic [31:0] frd,
                                input logic [31:0] drd);
        vec_t v;
        v.dr = dr; v.da = da; v.dw = dw; v.dd = dd; v.fr = fr; v.fa = fa; v.mc = mc;
        v.flags = flags; v.ma = ma; v.mwd = mwd; v.frd = frd; v.drd = drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic dr, input logic [31:0] da, input logic dw,
                         input logic [31:0] dd, input logic fr, input logic [31:0] fa,
                         input logic mc);
        @(negedge clock);
        reset = rst;
        d_req = dr; d_addr = da; d_w_enable = dw; d_w_data = dd;
        f_req = fr; f_addr = fa; mmio_write_complete = mc;
        #2;
    endtask

    task automatic run_mmio(input string tag, input logic [31:0] addr, input int comp_at,
                            input logic f_on);
        int   exit_cyc;
        logic exp_err;
        if (comp_at >= 0 && comp_at <= TIMEOUT) begin
            exit_cyc = comp_at;
            exp_err  = 1'b0;
        end else begin
            exit_cyc = TIMEOUT;
            exp_err  = 1'b1;
        end
        for (int k = 0; k <= exit_cyc; k++) begin
            drive(1'b0, k == 0, addr, 1'b1, addr + 32'd1, f_on, 32'h10, k == comp_at);
            check($sformatf("%s c%0d gnt/done/we", tag, k),
                  {28'h0, d_gnt, f_gnt, d_done, mem_w_enable}, {28'h0, k == 0, 1'b0, 1'b0, 1'b1});
            check($sformatf("%s c%0d mem_addr", tag, k), mem_addr, addr);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, f_on, 32'h10, 1'b0);
        check($sformatf("%s end done/err/we/f_gnt", tag),
              {28'h0, d_done, d_err, mem_w_enable, f_gnt}, {28'h0, 1'b1, exp_err, 1'b0, f_on});
        if (f_on) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check($sformatf("%s f_done", tag), {31'h0, f_done}, 32'h1);
            check($sformatf("%s f_r_data", tag), f_r_data, 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b100000, 32'h44,    0, 0, 0);
        vecs[1]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b001000, 32'h44,    0, 0, 32'h0BAD_C0DE);
        vecs[2]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b010000, 32'h40,    0, 0, 0);
        vecs[3]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b000100, 32'h40,    0, 32'hCAFE_F00D, 0);
        vecs[4]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b100000, 32'h44,    0, 0, 0);
        vecs[5]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b001000, 32'h44,    0, 0, 32'h0BAD_C0DE);
        vecs[6]  = mk(1, 32'h44,    0, 0,            1, 32'h40, 0, 6'b010000, 32'h40,    0, 0, 0);
        vecs[7]  = mk(0, 0,         0, 0,            0, 0,      0, 6'b000100, 32'h40,    0, 32'hCAFE_F00D, 0);
        vecs[8]  = mk(0, 0,         0, 0,            1, 32'h10, 0, 6'b010000, 32'h10,    0, 0, 0);
        vecs[9]  = mk(0, 0,         0, 0,            0, 0,      0, 6'b000100, 32'h10,    0, 32'hDEAD_BEEF, 0);
        vecs[10] = mk(1, 32'h20000, 1, 32'h12345678, 0, 0,      0, 6'b100001, 32'h20000, 32'h12345678, 0, 0);
        vecs[11] = mk(1, 32'h20000, 0, 0,            0, 0,      0, 6'b101000, 32'h20000, 0, 0, 0);
        vecs[12] = mk(0, 0,         0, 0,            0, 0,      0, 6'b001000, 32'h20000, 0, 0, 32'h12345678);
        vecs[13] = mk(1, 32'h100,   1, 32'hAA55,     0, 0,      1, 6'b100001, 32'h100,   32'hAA55, 0, 0);
        vecs[14] = mk(0, 0,         0, 0,            0, 0,      0, 6'b001000, 0,         0, 0, 0);
        vecs[15] = mk(1, 32'h10000, 1, 32'h1,        0, 0,      0, 6'b100001, 32'h10000, 32'h1, 0, 0);
        vecs[16] = mk(1, 32'hFFFF,  1, 32'h2,        0, 0,      0, 6'b101001, 32'hFFFF,  32'h2, 0, 0);
        vecs[17] = mk(0, 0,         0, 0,            1, 32'h10, 0, 6'b000001, 32'hFFFF,  32'h2, 0, 0);
        vecs[18] = mk(0, 0,         0, 0,            1, 32'h10, 1, 6'b000001, 32'hFFFF,  32'h2, 0, 0);
        vecs[19] = mk(0, 0,         0, 0,            1, 32'h10, 0, 6'b011000, 32'h10,    0, 0, 0);
        vecs[20] = mk(0, 0,         0, 0,            0, 0,      0, 6'b000100, 32'h10,    0, 32'hDEAD_BEEF, 0);
        vecs[21] = mk(0, 0,         0, 0,            0, 0,      0, 6'b000000, 0,         0, 0, 0);

        reset = 1'b1;
        d_req = 1'b0; d_addr = '0; d_w_enable = 1'b0; d_w_data = '0; d_w_width = 2'd2;
        f_req = 1'b0; f_addr = '0; mmio_write_complete = 1'b0;

        // Requests present during reset must see nothing.
        drive(1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        check("reset flags", {26'h0, act_flags}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset f_r_data", f_r_data, 32'h0);
        check("reset d_r_data", d_r_data, 32'h0);

        for (int i = 0; i < 22; i++) begin
            drive(1'b0, vecs[i].dr, vecs[i].da, vecs[i].dw, vecs[i].dd,
                  vecs[i].fr, vecs[i].fa, vecs[i].mc);
            check($sformatf("vec%0d flags", i), {26'h0, act_flags}, {26'h0, vecs[i].flags});
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].ma);
            check($sformatf("vec%0d mem_w_data", i), mem_w_data, vecs[i].mwd);
            check($sformatf("vec%0d f_r_data", i), f_r_data, vecs[i].frd);
            check($sformatf("vec%0d d_r_data", i), d_r_data, vecs[i].drd);
        end

        run_mmio("mmio_c5", 32'h200, 5, 1'b1);
        run_mmio("mmio_to", 32'h300, -1, 1'b1);
        run_mmio("mmio_c_at_limit", 32'h300, TIMEOUT, 1'b0);

        // Reset while a fetch read is outstanding.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check("rst_rw grant", {26'h0, act_flags}, 32'b010000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_rw flags", {26'h0, act_flags}, 32'h0);
        check("rst_rw f_r_data", f_r_data, 32'h0);
        check("rst_rw mem_addr", mem_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check("rst_rw next grant D", {26'h0, act_flags}, 32'b100000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_rw2 flags", {26'h0, act_flags}, 32'h0);

        // Reset while an MMIO write is waiting.
        drive(1'b0, 1'b1, 32'h400, 1'b1, 32'h55, 1'b1, 32'h10, 1'b0);
        check("rst_mw grant", {26'h0, act_flags}, 32'b100001);
        drive(1'b0, 1'b0, 32'h400, 1'b1, 32'h55, 1'b1, 32'h10, 1'b0);
        check("rst_mw waiting", {26'h0, act_flags}, 32'b000001);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check("rst_mw flags", {26'h0, act_flags}, 32'h0);
        check("rst_mw mem_addr", mem_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check("rst_mw next grant D", {26'h0, act_flags}, 32'b100000);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_mw read done", {26'h0, act_flags}, 32'b001000);
        check("rst_mw read data", d_r_data, 32'h0BAD_C0DE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
